// File: rtl/sr04_controller_pkg.sv
// Shared constants for the HC-SR04 ranger: FSM encoding, output width and
// helpers that derive counter widths and the microsecond tick divisor.
package sr04_controller_pkg;

  // FSM state encoding (plain constants so older tools can consume them)
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_TRIG      = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_ECHO = 3'd2;
  localparam logic [STATE_W-1:0] ST_MEASURE   = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE      = 3'd4;

  // Width of the published distance (matches the display controller input)
  localparam int DIST_W = 11;

  localparam int US_PER_SEC = 1_000_000;

  // Clocks per microsecond tick; the clock must be a whole number of MHz, >= 1 MHz
  function automatic int tick_div(input int clk_freq_hz);
    return clk_freq_hz / US_PER_SEC;
  endfunction

  // $clog2 that never returns 0, so a counter always has at least one bit
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen_us.sv
// Free-running 1 us tick generator: one-clock pulse every TICK_DIV clocks.
// clr restarts the period so a measurement begins on a clean tick phase.
module tick_gen_us
  import sr04_controller_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int TICK_DIV = tick_div(CLK_FREQ_HZ);
  localparam int CNT_W    = clog2_min1(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wrap at the end of the period or restart on clr
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // Period counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/sr04_controller.sv
// HC-SR04 controller: issues the trigger pulse, times the echo high pulse in
// microseconds and converts it to whole centimetres by counting US_PER_CM
// ticks per centimetre (no divider). Publishes distance with a done strobe.
module sr04_controller
  import sr04_controller_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TRIG_US     = 10,
  parameter int US_PER_CM   = 58,
  parameter int TIMEOUT_US  = 25_000,
  parameter int MAX_CM      = 400      // must fit in the 11-bit distance output
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        echo,
  output logic        trigger,
  output logic [10:0] distance,
  output logic        dist_done,
  output logic        busy,
  output logic        timeout_err
);

  localparam int TRIG_W = clog2_min1(TRIG_US);
  localparam int TO_W   = clog2_min1(TIMEOUT_US + 1);
  localparam int SUB_W  = clog2_min1(US_PER_CM);
  localparam int CM_W   = clog2_min1(MAX_CM + 1);

  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_US - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_US - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(US_PER_CM - 1);
  localparam logic [CM_W-1:0]   CM_MAX    = CM_W'(MAX_CM);

  logic [STATE_W-1:0] state_q, state_d;
  logic [TRIG_W-1:0]  trig_cnt_q, trig_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [SUB_W-1:0]   sub_cnt_q, sub_cnt_d;
  logic [CM_W-1:0]    cm_cnt_q, cm_cnt_d;
  logic [10:0]        distance_q, distance_d;
  logic               timeout_err_q, timeout_err_d;

  logic echo_s1_q, echo_s2_q, echo_d_q;
  logic echo_rise, echo_fall;
  logic tick, tick_clr;

  tick_gen_us #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // Two-flop echo synchronizer plus a delay flop for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
      echo_d_q  <= 1'b0;
    end else begin
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
      echo_d_q  <= echo_s2_q;
    end
  end

  assign echo_rise = echo_s2_q & ~echo_d_q;
  assign echo_fall = ~echo_s2_q & echo_d_q;

  // Measurement sequencer: next state, counters and published results
  always_comb begin
    state_d       = state_q;
    trig_cnt_d    = trig_cnt_q;
    to_cnt_d      = to_cnt_q;
    sub_cnt_d     = sub_cnt_q;
    cm_cnt_d      = cm_cnt_q;
    distance_d    = distance_q;
    timeout_err_d = timeout_err_q;
    tick_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_TRIG;
          tick_clr   = 1'b1;
          trig_cnt_d = '0;
          to_cnt_d   = '0;
          sub_cnt_d  = '0;
          cm_cnt_d   = '0;
        end
      end

      ST_TRIG: begin
        if (tick) begin
          if (trig_cnt_q == TRIG_LAST) begin
            state_d = ST_WAIT_ECHO;
          end else begin
            trig_cnt_d = trig_cnt_q + 1'b1;
          end
        end
      end

      ST_WAIT_ECHO, ST_MEASURE: begin
        if (tick) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
        // The tick in the echo-fall cycle still counts, so the measured
        // window spans exactly the synchronized echo high time.
        if ((state_q == ST_MEASURE) && tick) begin
          if (sub_cnt_q == SUB_LAST) begin
            sub_cnt_d = '0;
            if (cm_cnt_q != CM_MAX) begin
              cm_cnt_d = cm_cnt_q + 1'b1;
            end
          end else begin
            sub_cnt_d = sub_cnt_q + 1'b1;
          end
        end
        // Timeout takes priority over any echo edge in the same cycle
        if (tick && (to_cnt_q == TO_LAST)) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else if ((state_q == ST_WAIT_ECHO) && echo_rise) begin
          state_d = ST_MEASURE;
        end else if ((state_q == ST_MEASURE) && echo_fall) begin
          state_d       = ST_DONE;
          distance_d    = DIST_W'(cm_cnt_d);
          timeout_err_d = 1'b0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      trig_cnt_q    <= '0;
      to_cnt_q      <= '0;
      sub_cnt_q     <= '0;
      cm_cnt_q      <= '0;
      distance_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      trig_cnt_q    <= trig_cnt_d;
      to_cnt_q      <= to_cnt_d;
      sub_cnt_q     <= sub_cnt_d;
      cm_cnt_q      <= cm_cnt_d;
      distance_q    <= distance_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign trigger     = (state_q == ST_TRIG);
  assign busy        = (state_q != ST_IDLE);
  assign dist_done   = (state_q == ST_DONE);
  assign distance    = distance_q;
  assign timeout_err = timeout_err_q;

endmodule
